sha256_msg_sched: RTL and testbench

- SHA-256 message-schedule stage, directly upstream of sha256_round.
- Accepts one padded 512-bit block. Streams W[0..63] one word per handshake so the round stage can consume them in order, together with the round index used to select K[t].
- Built around a 16-word sliding window with an on-the-fly expansion adder. Stalls cleanly when the round stage deasserts ready.

---
 rtl/sha256_pkg.sv | 62 ++++++
 rtl/sha256_msg_sched_if.sv | 53 +++++
 rtl/sha256_sched_word.sv | 18 +
 rtl/sha256_msg_sched.sv | 138 +++++++++++++
 tb/tb_sha256_msg_sched.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 definitions.
//   - word and round-count constants
//   - K round-constant table (64 x 32)
//   - small sigma functions (message schedule) and big Sigma functions (round stage)
//   - scheduler FSM state type
// No ports; imported by the scheduler, its interface and the round stage.

package sha256_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned SHA256_ROUNDS = 64;
    localparam int unsigned WIN_WORDS     = 16;
    localparam int unsigned BLK_W         = WORD_W * WIN_WORDS;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } sched_state_e;

    localparam word_t K [SHA256_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Callers pass constant shift amounts, so these reduce to pure wiring.
    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// sha256_msg_sched_if: block-in / schedule-word-out bus of the message scheduler.
//   blk_data  [511:0]  padded block, W[0] in bits [511:480]
//   blk_valid / blk_ready  block handshake
//   w_out [31:0], w_idx [5:0], w_last  current schedule word, round index, final-word flag
//   w_valid / w_ready  word handshake
//   wk_out [31:0]  W[t] + K[t], present only when SHA256_SCHED_WK_EN is defined
// Modports: master = environment side (block source and round-stage sink),
//           slave  = scheduler side.

interface sha256_msg_sched_if;
    import sha256_pkg::*;

    logic [BLK_W-1:0] blk_data;
    logic             blk_valid;
    logic             blk_ready;
    word_t            w_out;
    logic [5:0]       w_idx;
    logic             w_last;
    logic             w_valid;
    logic             w_ready;
`ifdef SHA256_SCHED_WK_EN
    word_t            wk_out;
`endif

    modport master (
        output blk_data,
        output blk_valid,
        input  blk_ready,
        input  w_out,
        input  w_idx,
        input  w_last,
        input  w_valid,
`ifdef SHA256_SCHED_WK_EN
        input  wk_out,
`endif
        output w_ready
    );

    modport slave (
        input  blk_data,
        input  blk_valid,
        output blk_ready,
        output w_out,
        output w_idx,
        output w_last,
        output w_valid,
`ifdef SHA256_SCHED_WK_EN
        output wk_out,
`endif
        input  w_ready
    );

endinterface

// File: rtl/sha256_sched_word.sv
// sha256_sched_word: combinational SHA-256 message expansion.
//   w_m16, w_m15, w_m7, w_m2  inputs W[t-16], W[t-15], W[t-7], W[t-2]
//   w_new                     output W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32

module sha256_sched_word
    import sha256_pkg::*;
(
    input  word_t w_m16,
    input  word_t w_m15,
    input  word_t w_m7,
    input  word_t w_m2,
    output word_t w_new
);

    // 32-bit result width drops the carries out of the sum.
    assign w_new = small_sigma1(w_m2) + w_m7 + small_sigma0(w_m15) + w_m16;

endmodule

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message-schedule stage feeding sha256_round.
// Accepts one padded 512-bit block, then streams W[0..ROUNDS-1] one word per
// handshake, together with the round index t and a last-word flag.
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    sha256_msg_sched_if.slave (block in, schedule words out)
// Parameter ROUNDS: words per block, 64 for SHA-256; 16..64 for reduced-round debug.
// Optional feature macro SHA256_SCHED_WK_EN: adds registered wk_out = W[t] + K[t].
//
// A 16-word window holds W[t..t+15]; win[0] is presented. Each word handshake
// shifts the window down and appends W[t+16] from the expansion adder.

module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = SHA256_ROUNDS
) (
    input  logic                  clk,
    input  logic                  reset,
    sha256_msg_sched_if.slave     bus
);

    if (ROUNDS < 16 || ROUNDS > 64) begin : g_bad_rounds
        $error("sha256_msg_sched: ROUNDS must be in 16..64");
    end

    localparam logic [5:0] LastIdx = 6'(ROUNDS - 1);

    sched_state_e state_q, state_d;
    logic [5:0]   t_q, t_d;
    word_t        win_q [WIN_WORDS];
    word_t        win_d [WIN_WORDS];
    word_t        w_next;

    logic run;
    logic is_last;

    assign run     = (state_q == StRun);
    assign is_last = (t_q == LastIdx);

    sha256_sched_word u_sched_word (
        .w_m16 (win_q[0]),
        .w_m15 (win_q[1]),
        .w_m7  (win_q[9]),
        .w_m2  (win_q[14]),
        .w_new (w_next)
    );

    // Next-state, index and window update.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;

        unique case (state_q)
            StIdle: begin
                if (bus.blk_valid) begin
                    for (int i = 0; i < int'(WIN_WORDS); i++) begin
                        win_d[i] = bus.blk_data[BLK_W-1-WORD_W*i -: WORD_W];
                    end
                    t_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.w_ready) begin
                    for (int i = 0; i < int'(WIN_WORDS) - 1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[WIN_WORDS-1] = w_next;
                    if (is_last) begin
                        t_d     = '0;
                        state_d = StIdle;
                    end else begin
                        t_d = t_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                t_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Window contents are meaningless outside RUN, so no reset is needed.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign bus.blk_ready = (state_q == StIdle);
    assign bus.w_valid   = run;
    assign bus.w_out     = run ? win_q[0] : '0;
    assign bus.w_idx     = t_q;
    assign bus.w_last    = run && is_last;

`ifdef SHA256_SCHED_WK_EN
    word_t wk_q, wk_d;

    // Precompute W+K for the word that will be presented next, so wk_out
    // changes on the same edge as w_out.
    always_comb begin
        wk_d = wk_q;
        if (state_q == StIdle) begin
            if (bus.blk_valid) begin
                wk_d = bus.blk_data[BLK_W-1 -: WORD_W] + K[0];
            end
        end else if (bus.w_ready) begin
            if (is_last) begin
                wk_d = '0;
            end else begin
                wk_d = win_q[1] + K[t_q + 6'd1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wk_q <= '0;
        end else begin
            wk_q <= wk_d;
        end
    end

    assign bus.wk_out = wk_q;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: randomized self-checking bench for sha256_msg_sched.
// Expected schedule words come from a textbook W[t] recurrence over an array.

module tb_sha256_msg_sched;

    logic clk;
    logic rst;

    sha256_msg_sched_if bus ();

    sha256_msg_sched #(
        .ROUNDS (64)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass;
    int unsigned n_total;

    logic [31:0] exp_w [64];
    logic [31:0] obs_w [64];
`ifdef SHA256_SCHED_WK_EN
    logic [31:0] obs_wk [64];
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_ref(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Present a block and wait (bounded) for acceptance; W[0] must follow at once.
    task automatic send_block(input logic [511:0] d);
        int cyc = 0;
        bus.blk_data  = d;
        bus.blk_valid = 1'b1;
        while (!bus.blk_ready && cyc < 300) begin
            step();
            cyc++;
        end
        if (!bus.blk_ready) check_eq("blk_accept_timeout", 64'(cyc), 64'd0);
        step();
        bus.blk_valid = 1'b0;
        check_eq("accept_w_valid", 64'(bus.w_valid), 64'd1);
        check_eq("accept_blk_ready", 64'(bus.blk_ready), 64'd0);
        check_eq("accept_w_idx", 64'(bus.w_idx), 64'd0);
        check_eq("accept_w0", 64'(bus.w_out), 64'(exp_w[0]));
    endtask

    // Consume n_words words with w_ready high ready_pct percent of cycles.
    task automatic consume(input int n_words, input int ready_pct);
        int          cnt = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [31:0] hold_w = '0;
        logic [5:0]  hold_i = '0;
        logic        hold_l = 1'b0;
        while (cnt < n_words && cyc < 4000) begin
            bus.w_ready = ($urandom_range(99) < ready_pct);
            if (bus.w_valid) begin
                check_eq("run_blk_ready", 64'(bus.blk_ready), 64'd0);
                if (stalled) begin
                    check_eq("stall_w_out", 64'(bus.w_out), 64'(hold_w));
                    check_eq("stall_w_idx", 64'(bus.w_idx), 64'(hold_i));
                    check_eq("stall_w_last", 64'(bus.w_last), 64'(hold_l));
                end
                if (bus.w_ready) begin
                    check_eq($sformatf("w_out[%0d]", cnt), 64'(bus.w_out), 64'(exp_w[cnt]));
                    check_eq($sformatf("w_idx[%0d]", cnt), 64'(bus.w_idx), 64'(cnt));
                    check_eq($sformatf("w_last[%0d]", cnt), 64'(bus.w_last),
                             64'(cnt == 63));
`ifdef SHA256_SCHED_WK_EN
                    check_eq($sformatf("wk_out[%0d]", cnt), 64'(bus.wk_out),
                             64'(32'(exp_w[cnt] + sha256_pkg::K[cnt])));
                    obs_wk[cnt] = bus.wk_out;
`endif
                    obs_w[cnt] = bus.w_out;
                    cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_w  = bus.w_out;
                    hold_i  = bus.w_idx;
                    hold_l  = bus.w_last;
                end
            end else begin
                check_eq("unexpected_w_valid_low", 64'(bus.w_valid), 64'd1);
            end
            step();
            cyc++;
        end
        if (cnt < n_words) check_eq("consume_timeout", 64'(cnt), 64'(n_words));
        if (cnt == 64) begin
            check_eq("post_last_blk_ready", 64'(bus.blk_ready), 64'd1);
            check_eq("post_last_w_valid", 64'(bus.w_valid), 64'd0);
        end
    endtask

    task automatic check_abc_words();
        check_eq("abc_w0", 64'(obs_w[0]), 64'h61626380);
        check_eq("abc_w15", 64'(obs_w[15]), 64'h00000018);
        check_eq("abc_w16", 64'(obs_w[16]), 64'h61626380);
        check_eq("abc_w17", 64'(obs_w[17]), 64'h000f0000);
`ifdef SHA256_SCHED_WK_EN
        check_eq("abc_wk0", 64'(obs_wk[0]), 64'ha3ec9318);
        check_eq("abc_wk1", 64'(obs_wk[1]), 64'h71374491);
`endif
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_w_valid"}, 64'(bus.w_valid), 64'd0);
        check_eq({tag, "_blk_ready"}, 64'(bus.blk_ready), 64'd1);
        check_eq({tag, "_w_idx"}, 64'(bus.w_idx), 64'd0);
        check_eq({tag, "_w_last"}, 64'(bus.w_last), 64'd0);
        check_eq({tag, "_w_out"}, 64'(bus.w_out), 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc;
        logic [511:0] blk_b;

        n_pass  = 0;
        n_total = 0;
        abc     = {32'h61626380, {14{32'h0}}, 32'h00000018};

        rst           = 1'b1;
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.w_ready   = 1'b0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        bus.w_ready = 1'b1;   // no effect while idle
        step();
        step();
        check_idle("idle_after_reset");

        // abc block, consumer always ready
        build_ref(abc);
        send_block(abc);
        consume(64, 100);
        check_abc_words();

        // abc block with random back-pressure
        send_block(abc);
        consume(64, 45);
        check_abc_words();

        // blk_valid held across two blocks, blk_data garbled during RUN
        blk_b = rand_block();
        build_ref(abc);
        bus.blk_data  = abc;
        bus.blk_valid = 1'b1;
        step();
        check_eq("b2b_first_accept", 64'(bus.w_valid), 64'd1);
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    bus.blk_data = rand_block();
                    step();
                end
                bus.blk_data = blk_b;
            end
            consume(64, 100);
        join
        build_ref(blk_b);
        step();
        bus.blk_valid = 1'b0;
        check_eq("b2b_second_valid", 64'(bus.w_valid), 64'd1);
        check_eq("b2b_second_idx", 64'(bus.w_idx), 64'd0);
        check_eq("b2b_second_w0", 64'(bus.w_out), 64'(exp_w[0]));
        consume(64, 70);

        // reset in the middle of a block
        build_ref(abc);
        send_block(abc);
        consume(30, 100);
        check_eq("pre_reset_valid", 64'(bus.w_valid), 64'd1);
        check_eq("pre_reset_idx", 64'(bus.w_idx), 64'd30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("mid_reset");
        step();
        check_idle("mid_reset_hold");
        send_block(abc);
        consume(64, 100);
        check_abc_words();

        // all-ones block
        build_ref({512{1'b1}});
        send_block({512{1'b1}});
        consume(64, 80);

        // random blocks with random back-pressure
        for (int b = 0; b < 4; b++) begin
            blk_b = rand_block();
            build_ref(blk_b);
            send_block(blk_b);
            consume(64, 60);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
